// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains a fifo read port one word at a time
// and serialises each word as an idle-high 8N1-style frame.
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  output logic                  tx_out,
  output logic                  busy_out
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  baud_end;

  assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  // Next state, next line level and counter updates.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q + CW'(1);
    tx_d    = tx_q;
    rd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        bit_d  = '0;
        baud_d = '0;
        if (!fifo_empty_in) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
        end
      end
      S_FETCH: begin
        baud_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        baud_d  = '0;
        shift_d = fifo_data_in;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_read_en_out = rd_q;
  assign tx_out           = tx_q;
  assign busy_out         = busy_q;

endmodule
